// File: rtl/pg_carry_resolver.sv
// Purpose : resolves per-bit propagate/generate vectors into sum and carry-out, CHUNK bits per cycle
//           over a registered running carry (area-lean alternative to a full prefix tree).
// Latency : accept at edge T -> out_valid after edge T+NUM_CHUNKS; one operand per NUM_CHUNKS+2 cycles.
// Backpr. : in_ready low from accept until the result is taken; sum/cout/out_valid held while !out_ready.
//
// Ports   : clk, rst (synchronous, active-high)
//           in_valid/in_ready + p, g, cin  -- operand side, sampled only on the accepting edge
//           out_valid/out_ready + sum, cout -- result side
//           overflow (only with PG_CARRY_RESOLVER_OVERFLOW_EN defined) -- signed overflow, valid with out_valid
// Config  : define PG_CARRY_RESOLVER_OVERFLOW_EN to add the overflow output; default build omits it.
//           WIDTH must be an integer multiple of CHUNK; NUM_CHUNKS = 1 is legal (single BUSY cycle).

module pg_carry_resolver #(
    parameter int WIDTH = 128,
    parameter int CHUNK = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] p,
    input  logic [WIDTH-1:0] g,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef PG_CARRY_RESOLVER_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int NUM_CHUNKS = WIDTH / CHUNK;
    // Keep the index at least one bit wide so NUM_CHUNKS = 1 still elaborates.
    localparam int IDX_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  p_q;
    logic [WIDTH-1:0]  g_q;
    logic              carry_q;
    logic [IDX_W-1:0]  idx_q;

    logic [CHUNK-1:0]  p_chunk;
    logic [CHUNK-1:0]  g_chunk;
    logic [CHUNK-1:0]  chunk_sum;
    logic              chunk_cout;
`ifdef PG_CARRY_RESOLVER_OVERFLOW_EN
    logic              chunk_msb_cin;
`endif

    // Ripple across the current chunk starting from the registered carry.
    always_comb begin
        logic c;
        p_chunk   = p_q[idx_q*CHUNK +: CHUNK];
        g_chunk   = g_q[idx_q*CHUNK +: CHUNK];
        chunk_sum = '0;
        c         = carry_q;
`ifdef PG_CARRY_RESOLVER_OVERFLOW_EN
        chunk_msb_cin = 1'b0;
`endif
        for (int i = 0; i < CHUNK; i++) begin
`ifdef PG_CARRY_RESOLVER_OVERFLOW_EN
            // On the last chunk this is the carry into bit WIDTH-1.
            if (i == CHUNK - 1) begin
                chunk_msb_cin = c;
            end
`endif
            // p&g both set cannot come from x^y / x&y; treat it as a pure
            // generate (x=y=1 has p=0), so the sum bit is just the incoming carry.
            chunk_sum[i] = (p_chunk[i] & ~g_chunk[i]) ^ c;
            c            = g_chunk[i] | (p_chunk[i] & c);
        end
        chunk_cout = c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            idx_q     <= '0;
            carry_q   <= 1'b0;
            p_q       <= '0;
            g_q       <= '0;
`ifdef PG_CARRY_RESOLVER_OVERFLOW_EN
            overflow  <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        p_q      <= p;
                        g_q      <= g;
                        carry_q  <= cin;
                        idx_q    <= '0;
                        in_ready <= 1'b0;
                        state    <= ST_BUSY;
                    end
                end

                ST_BUSY: begin
                    // Untouched chunks keep the previous result until overwritten.
                    sum[idx_q*CHUNK +: CHUNK] <= chunk_sum;
                    carry_q                   <= chunk_cout;
                    if (idx_q == LAST_IDX) begin
                        cout      <= chunk_cout;
`ifdef PG_CARRY_RESOLVER_OVERFLOW_EN
                        overflow  <= chunk_msb_cin ^ chunk_cout;
`endif
                        out_valid <= 1'b1;
                        idx_q     <= '0;
                        state     <= ST_DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end

                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end

                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pg_carry_resolver.sv
// Purpose : directed self-checking bench for pg_carry_resolver (default WIDTH=128, CHUNK=32).
// Latency : expects out_valid exactly 4 edges after the accepting edge.
// Backpr. : exercises held results under out_ready=0 and back-to-back operands.

module tb_pg_carry_resolver;

    localparam int W = 128;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] p = '0;
    logic [W-1:0] g = '0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
`ifdef PG_CARRY_RESOLVER_OVERFLOW_EN
    logic         overflow;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pg_carry_resolver #(.WIDTH(128), .CHUNK(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .p         (p),
        .g         (g),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef PG_CARRY_RESOLVER_OVERFLOW_EN
        ,
        .overflow  (overflow)
`endif
    );

    task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Present one operand, wait (bounded) for the result and check it.
    // Leaves out_valid asserted; the caller decides when to take it.
    task automatic run_op(input string tag, input logic [W-1:0] pp, input logic [W-1:0] gg,
                          input logic cc, input logic [W-1:0] esum, input logic ecout);
        int lat;
        @(negedge clk);
        check({tag, "_in_ready"}, in_ready, 1);
        in_valid = 1'b1;
        p = pp;
        g = gg;
        cin = cc;
        @(negedge clk);
        in_valid = 1'b0;
        p = ~pp;
        g = '0;
        cin = ~cc;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, lat, 4);
        check({tag, "_sum"}, sum, esum);
        check({tag, "_cout"}, cout, ecout);
    endtask

    task automatic take_result(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_out_valid_drop"}, out_valid, 0);
        check({tag, "_in_ready_back"}, in_ready, 1);
    endtask

    initial begin
        logic [W-1:0] held_sum;
        int pulses;
        int lat;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_sum", sum, 0);
        check("reset_cout", cout, 0);

        // 5 + 3 = 8
        run_op("add_5_3", 128'h6, 128'h1, 1'b0, 128'h8, 1'b0);
        take_result("add_5_3");

        // all ones + 1: carry ripples across every chunk
        run_op("ones_plus_1", ~128'h1, 128'h1, 1'b0, 128'h0, 1'b1);
`ifdef PG_CARRY_RESOLVER_OVERFLOW_EN
        check("ones_plus_1_ovf", overflow, 0);
`endif
        take_result("ones_plus_1");

        // 0x7FFF..FF + 1: signed overflow into the MSB
        run_op("max_pos_plus_1", {1'b0, {126{1'b1}}, 1'b0}, 128'h1, 1'b0,
               {1'b1, 127'h0}, 1'b0);
`ifdef PG_CARRY_RESOLVER_OVERFLOW_EN
        check("max_pos_plus_1_ovf", overflow, 1);
`endif
        take_result("max_pos_plus_1");

        // carry-in only
        run_op("cin_only", 128'h0, 128'h0, 1'b1, 128'h1, 1'b0);
        take_result("cin_only");

        // 0xFFFFFFFF + 1: carry crosses the first chunk boundary only
        run_op("chunk_cross", 128'hFFFF_FFFE, 128'h1, 1'b0, 128'h1_0000_0000, 1'b0);
        take_result("chunk_cross");

        // illegal p&g at bit 0 behaves as generate
        run_op("pg_both", 128'h1, 128'h1, 1'b0, 128'h2, 1'b0);
        take_result("pg_both");

        // Hold result with out_ready low while fresh inputs are offered
        run_op("hold", 128'h5115, 128'h0220, 1'b0, 128'h5555, 1'b0);
        held_sum = sum;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            p = {4{$urandom}};
            g = '0;
            @(negedge clk);
            check("hold_sum", sum, 128'h5555);
            check("hold_cout", cout, 0);
            check("hold_in_ready", in_ready, 0);
            check("hold_out_valid", out_valid, 1);
        end
        in_valid = 1'b0;
        take_result("hold");
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        check("hold_no_ghost_result", pulses, 0);

        // Reset in the second BUSY cycle discards the operand
        @(negedge clk);
        in_valid = 1'b1;
        p = '1;
        g = '0;
        cin = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_sum", sum, 0);
        check("midrst_cout", cout, 0);
        rst = 1'b0;
        pulses = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        check("midrst_no_pulse", pulses, 0);
        run_op("after_rst_2_2", 128'h0, 128'h2, 1'b0, 128'h4, 1'b0);
        take_result("after_rst_2_2");

        // Back-to-back: in_valid held high, out_ready held high
        @(negedge clk);
        out_ready = 1'b1;
        in_valid = 1'b1;
        p = 128'hE;
        g = 128'h1;
        cin = 1'b0;
        @(negedge clk);
        check("b2b_a_accepted", in_ready, 0);
        p = 128'h5115;
        g = 128'h0220;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("b2b_a_latency", lat, 4);
        check("b2b_a_sum", sum, 128'h10);
        @(negedge clk);
        check("b2b_a_taken", out_valid, 0);
        check("b2b_b_not_yet", in_ready, 1);
        @(negedge clk);
        check("b2b_b_accepted", in_ready, 0);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("b2b_b_latency", lat, 4);
        check("b2b_b_sum", sum, 128'h5555);
        check("b2b_b_cout", cout, 0);
        @(negedge clk);
        out_ready = 1'b0;
        check("b2b_b_taken", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
